// File: rtl/mult_pipe_pkg.sv
// Shared ALU definitions: function-select encodings and multiplier operand-sign helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mult_pipe_pkg;

  // ALU operation select. Only the four multiplier encodings are handled by mult_pipe.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_MUL    = 4'd8,
    ALU_MULH   = 4'd9,
    ALU_MULHU  = 4'd10,
    ALU_MULHSU = 4'd11
  } AluFunc;

  // Operand A is treated as two's complement for MULH and MULHSU.
  function automatic logic a_is_signed(AluFunc f);
    return (f == ALU_MULH) || (f == ALU_MULHSU);
  endfunction

  // Operand B is treated as two's complement only for MULH.
  function automatic logic b_is_signed(AluFunc f);
    return (f == ALU_MULH);
  endfunction

endpackage

// File: rtl/mult_stage.sv
// One pipeline register slice carrying valid, tag, function select and payload.
// Latency: 1 cycle when enabled.
// Backpressure: holds every field while i_en = 0; flush clears valid regardless of enable.
module mult_stage
  import mult_pipe_pkg::*;
#(
  parameter int PAY_W = 64,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_vld,
  input  logic [TAG_W-1:0] i_tag,
  input  AluFunc           i_func,
  input  logic [PAY_W-1:0] i_pay,
  output logic             o_vld,
  output logic [TAG_W-1:0] o_tag,
  output AluFunc           o_func,
  output logic [PAY_W-1:0] o_pay
);

  logic             r_vld;
  logic [TAG_W-1:0] r_tag;
  AluFunc           r_func;
  logic [PAY_W-1:0] r_pay;

  // Register slice: reset beats flush, flush beats advance; sideband/payload move only on enable.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld  <= 1'b0;
      r_tag  <= '0;
      r_func <= ALU_ADD;
      r_pay  <= '0;
    end else begin
      if (i_flush) begin
        r_vld <= 1'b0;
      end else if (i_en) begin
        r_vld <= i_vld;
      end
      if (i_en) begin
        r_tag  <= i_tag;
        r_func <= i_func;
        r_pay  <= i_pay;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_tag  = r_tag;
  assign o_func = r_func;
  assign o_pay  = r_pay;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined WIDTH x WIDTH multiplier (MUL/MULH/MULHU/MULHSU) returning a sideband tag.
// Latency: STAGES cycles from acceptance to out_valid when not stalled.
// Backpressure: whole pipe advances on out_ready || !out_valid; in_ready equals that enable.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  AluFunc           alufunc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PROD_W = 2 * WIDTH;

  logic              w_en;
  logic [PROD_W-1:0] w_a_ext;
  logic [PROD_W-1:0] w_b_ext;

  // Index 0 is the input side; index STAGES is the output register.
  logic              w_vld  [0:STAGES];
  logic [TAG_W-1:0]  w_tag  [0:STAGES];
  AluFunc            w_func [0:STAGES];
  logic [PROD_W-1:0] w_pay  [0:STAGES];

  assign w_en     = out_ready || !out_valid;
  assign in_ready = w_en;

  // Extending both operands to 2*WIDTH with the per-function sign makes the truncated
  // product exact for every signedness combination, so one multiplier serves all four ops.
  assign w_a_ext = {{WIDTH{a_is_signed(alufunc) & a[WIDTH-1]}}, a};
  assign w_b_ext = {{WIDTH{b_is_signed(alufunc) & b[WIDTH-1]}}, b};

  assign w_vld[0]  = in_valid;
  assign w_tag[0]  = in_tag;
  assign w_func[0] = alufunc;
  assign w_pay[0]  = w_a_ext * w_b_ext;

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      mult_stage #(
        .PAY_W (PROD_W),
        .TAG_W (TAG_W)
      ) u_stage (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_en    (w_en),
        .i_flush (flush),
        .i_vld   (w_vld[g]),
        .i_tag   (w_tag[g]),
        .i_func  (w_func[g]),
        .i_pay   (w_pay[g]),
        .o_vld   (w_vld[g+1]),
        .o_tag   (w_tag[g+1]),
        .o_func  (w_func[g+1]),
        .o_pay   (w_pay[g+1])
      );
    end
  endgenerate

  assign out_valid = w_vld[STAGES];
  assign out_tag   = w_tag[STAGES];

  // Result half select from the registered full product; unsupported functions yield zero.
  always_comb begin
    data_out = '0;
    case (w_func[STAGES])
      ALU_MUL:                          data_out = w_pay[STAGES][WIDTH-1:0];
      ALU_MULH, ALU_MULHU, ALU_MULHSU:  data_out = w_pay[STAGES][PROD_W-1:WIDTH];
      default:                          data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe (WIDTH=32, STAGES=3, TAG_W=5).
// Directed vector table and corner sequences plus randomized traffic against a scoreboard.
// Checks results, latency, ordering, stall stability, flush and reset behaviour.
module tb_mult_pipe;
  import mult_pipe_pkg::*;

  localparam int W  = 32;
  localparam int ST = 3;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  AluFunc        alufunc = ALU_ADD;
  logic [TW-1:0] in_tag = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  data_out;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  mult_pipe #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alufunc   (alufunc),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_tag   (out_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_deliv = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: full mathematical product in 64-bit arithmetic, then pick the half.
  function automatic logic [W-1:0] model(AluFunc f, logic [W-1:0] x, logic [W-1:0] y);
    longint          sx = longint'(signed'(x));
    longint          sy = longint'(signed'(y));
    longint unsigned ux = {32'b0, x};
    longint unsigned uy = {32'b0, y};
    logic [63:0]     p;
    case (f)
      ALU_MUL:    begin p = ux * uy;            return p[31:0];  end
      ALU_MULH:   begin p = sx * sy;            return p[63:32]; end
      ALU_MULHU:  begin p = ux * uy;            return p[63:32]; end
      ALU_MULHSU: begin p = sx * longint'(uy);  return p[63:32]; end
      default:    return '0;
    endcase
  endfunction

  typedef struct packed {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
  } exp_t;
  exp_t q[$];

  logic          prev_clr = 1'b1;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  held_d = '0;
  logic [TW-1:0] held_t = '0;

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      prev_clr   = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (prev_clr) begin
        check("post_clear_out_valid", 64'(out_valid), 64'd0);
      end else if (prev_stall) begin
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        check("stall_hold_data", 64'(data_out), 64'(held_d));
        check("stall_hold_tag", 64'(out_tag), 64'(held_t));
      end
      check("in_ready_rule", 64'(in_ready), 64'(out_ready || !out_valid));
      if (out_valid && out_ready) begin
        n_deliv++;
        if (q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("sb_data", 64'(data_out), 64'(e.d));
          check("sb_tag", 64'(out_tag), 64'(e.t));
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back({model(alufunc, a, b), in_tag});
      prev_clr   = flush;
      prev_stall = out_valid && !out_ready && !flush;
      held_d     = data_out;
      held_t     = out_tag;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(AluFunc f, logic [W-1:0] x, logic [W-1:0] y, logic [TW-1:0] t);
    in_valid = 1'b1;
    alufunc  = f;
    a        = x;
    b        = y;
    in_tag   = t;
  endtask

  typedef struct {
    AluFunc        f;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [TW-1:0] t;
    logic [W-1:0]  exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;
    int issued;
    bit saw_full;

    vecs[0] = '{ALU_MUL,    32'h7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB};
    vecs[1] = '{ALU_MULH,   32'h80000000, 32'h80000000, 5'd4,  32'h40000000};
    vecs[2] = '{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE};
    vecs[3] = '{ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF};
    vecs[4] = '{ALU_ADD,    32'h12345678, 32'h12345678, 5'd7,  32'h0};
    vecs[5] = '{ALU_MUL,    32'h00010000, 32'h00010000, 5'd8,  32'h0};
    vecs[6] = '{ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h0};
    vecs[7] = '{ALU_MULHU,  32'h80000000, 32'h2,        5'd10, 32'h1};
    vecs[8] = '{ALU_MULHSU, 32'h80000000, 32'h2,        5'd11, 32'hFFFFFFFF};
    vecs[9] = '{AluFunc'(4'hF), 32'h12345678, 32'h12345678, 5'd31, 32'h0};

    // Reset state
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Vector table, one operation at a time, latency measured in edges
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].t);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        step();
        in_valid = 1'b0;
        if (out_valid) begin
          lat = k;
          break;
        end
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(ST));
      check($sformatf("vec%0d_data", i), 64'(data_out), 64'(vecs[i].exp));
      check($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].t));
    end
    step();

    // Back-to-back issue, results on consecutive cycles
    drive(ALU_MULH,   32'h80000000, 32'h80000000, 5'd1); step();
    drive(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2); step();
    drive(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3); step();
    in_valid = 1'b0;
    check("b2b_0_valid", 64'(out_valid), 64'd1);
    check("b2b_0_data", 64'(data_out), 64'h40000000);
    step();
    check("b2b_1_valid", 64'(out_valid), 64'd1);
    check("b2b_1_data", 64'(data_out), 64'hFFFFFFFE);
    step();
    check("b2b_2_valid", 64'(out_valid), 64'd1);
    check("b2b_2_data", 64'(data_out), 64'hFFFFFFFF);
    step();
    step();

    // Five ops with the consumer stalled for six cycles
    issued = 0;
    saw_full = 1'b0;
    d0 = n_deliv;
    for (int c = 0; c < 60; c++) begin
      out_ready = !(c >= 2 && c < 8);
      if (issued < 5) drive(ALU_MUL, 32'(issued + 2), 32'(issued + 100), 5'(issued + 10));
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && !in_ready) saw_full = 1'b1;
      if (in_valid && in_ready) issued++;
      step();
      if (n_deliv - d0 == 5) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stall_in_ready_dropped", 64'(saw_full), 64'd1);
    check("stall_issued", 64'(issued), 64'd5);
    check("stall_delivered", 64'(n_deliv - d0), 64'd5);
    step();

    // Flush with three in flight, stalled output and a same-cycle offer
    drive(ALU_MUL, 32'd11, 32'd12, 5'd1); step();
    drive(ALU_MUL, 32'd13, 32'd14, 5'd2); step();
    drive(ALU_MUL, 32'd15, 32'd16, 5'd3); step();
    drive(ALU_MUL, 32'd17, 32'd18, 5'd4);
    out_ready = 1'b0;
    flush = 1'b1;
    d0 = n_deliv;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (6) step();
    check("flush_nothing_emerged", 64'(n_deliv - d0), 64'd0);
    drive(ALU_MUL, 32'd3, 32'd5, 5'd21);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check("post_flush_latency", 64'(lat), 64'(ST));
    check("post_flush_data", 64'(data_out), 64'd15);
    check("post_flush_tag", 64'(out_tag), 64'd21);
    step();

    // Flush coinciding with a delivery: that one result counts
    drive(ALU_MUL, 32'd2, 32'd2, 5'd1); step();
    drive(ALU_MUL, 32'd3, 32'd3, 5'd2); step();
    drive(ALU_MUL, 32'd4, 32'd4, 5'd3); step();
    in_valid = 1'b0;
    flush = 1'b1;
    d0 = n_deliv;
    step();
    flush = 1'b0;
    repeat (5) step();
    check("flush_with_delivery_count", 64'(n_deliv - d0), 64'd1);

    // Reset with two in flight
    drive(ALU_MULHU, 32'hDEADBEEF, 32'hCAFEF00D, 5'd9); step();
    drive(ALU_MUL,   32'h1234,     32'h5678,     5'd10); step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    d0 = n_deliv;
    step();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_data_out", 64'(data_out), 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (6) step();
    check("midrst_nothing_emerged", 64'(n_deliv - d0), 64'd0);

    // Randomized traffic with random backpressure and occasional flush
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      alufunc   = AluFunc'(4'($urandom_range(0, 15)));
      a         = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b         = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      in_tag    = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      step();
    end
    check("random_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
